wb_stage: RTL
=============

Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS pipeline. It sits directly upstream of the register file.
- Holds the MEM/WB pipeline register, selects the write-back value (ALU result, aligned/extended load data, or link address) and drives the register file write port.
- Suppresses writes to register 0 and misaligned loads, flags misalignment, and counts retired instructions.

Parameters:
- ADDR_W, 6, register address width; must match the register file write address.
- DATA_W, 32, data path width; only 32 is supported.
- CNT_W, 32, retire counter width.

Ports:
- SYS_clk  in  1  system clock; all state updates on the rising edge.
- SYS_reset  in  1  synchronous, active-high reset.
- WB_flush  in  1  squash the instruction being captured this edge.
- WB_valid_in  in  1  MEM stage presents a valid instruction.
- WB_reg_write_in  in  1  instruction writes a register.
- WB_address_wr_in  in  ADDR_W  destination register.
- WB_sel_in  in  2  write-back source: 0 ALU, 1 LOAD, 2 LINK, 3 reserved (treated as ALU).
- WB_load_type_in  in  3  load type: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5-7 treated as LW.
- WB_byte_offset_in  in  2  effective address bits [1:0].
- WB_alu_result_in  in  DATA_W  ALU result.
- WB_mem_data_in  in  DATA_W  raw aligned word read from data memory.
- WB_pc_plus8_in  in  DATA_W  link address.
- REG_write_1  out  1  register file write enable.
- REG_address_wr  out  ADDR_W  register file write address.
- REG_data_wb_in1  out  DATA_W  register file write data.
- WB_misalign  out  1  current slot holds a misaligned load.
- WB_misalign_sticky  out  1  a misaligned load has been seen since reset.
- WB_retire_count  out  CNT_W  number of retired instructions.

Behaviour:
- Pipeline register update, every edge, in priority order:
  - SYS_reset: register clears.
  - WB_flush: register captures a bubble (valid=0); flush overrides WB_valid_in.
  - Otherwise: register captures all *_in fields.
- Latency: an instruction presented at edge N drives the write port during cycle N..N+1. The register file commits it at edge N+1. All outputs are combinational from registered state only; there is no input-to-output combinational path.
- Misalign detection, on registered fields:
  - misalign = valid & sel==LOAD & ((LW & off!=0) | ((LH|LHU) & off[0])).
  - Byte loads are never misaligned.
- Write enable: REG_write_1 = valid & reg_write & (addr!=0) & !misalign.
- REG_address_wr is always the registered address, whether or not a write is enabled.
- Write data:
  - ALU: alu_result.
  - LINK: pc_plus8.
  - LOAD, little-endian; offset 0 selects bits [7:0]:
    - LW: word.
    - LH/LHU: halfword at off[1] (0 selects [15:0], 1 selects [31:16]), sign- or zero-extended.
    - LB/LBU: byte at off, sign- or zero-extended.
  - When misaligned, the data value is don't-care; the write is blocked by the enable.
- WB_misalign equals misalign; it is high for exactly the cycles that slot is resident.
- WB_misalign_sticky: set on any edge where misalign=1; cleared only by SYS_reset.
- Retire counter:
  - Increments on each edge where valid & !misalign. This includes valid instructions with reg_write=0 and writes to addr 0.
  - Wraps from 2^CNT_W-1 to 0.
  - Reset has priority over increment.
- Simultaneous SYS_reset and WB_flush: reset wins. Both leave valid=0.
- Reset mid-operation: a resident instruction is discarded and not written. REG_write_1 is 0 from the cycle after the reset edge.
- Reset value of every output: REG_write_1=0, REG_address_wr=0, REG_data_wb_in1=0, WB_misalign=0, WB_misalign_sticky=0, WB_retire_count=0.
- Back-to-back valid instructions retire one per cycle. There are no stalls; upstream inserts bubbles via WB_valid_in=0.

Decomposition:
- Shared package wb_pkg holds:
  - WB_SEL_ALU/LOAD/LINK encodings.
  - LD_LW/LH/LHU/LB/LBU encodings.
  - DATA_W and ADDR_W defaults, also used by the register file and MEM stage.
- One combinational sub-module, load_align: inputs raw word, load type and offset; outputs extended data and misalign flag.

Test Plan:
- Reset, then ALU write: valid, sel=ALU, addr=5, alu=0x12345678 -> next cycle REG_write_1=1, addr=5, data=0x12345678; WB_retire_count=1 after the following edge.
- Load extraction: mem=0x80FF7F01 -> expected results:
  - LB off=3: 0xFFFFFF80.
  - LBU off=1: 0x0000007F.
  - LH off=2: 0xFFFF80FF.
  - LHU off=0: 0x00007F01.
  - LW off=0: 0x80FF7F01.
- Misaligned loads: LW off=2, then LH off=1 -> REG_write_1=0 and WB_misalign=1 each cycle; sticky=1 and stays 1; retire count unchanged; next LB off=1 writes normally.
- Register 0 and link: addr=0, reg_write=1 -> REG_write_1=0 but count increments. JAL with sel=LINK, addr=31, pc_plus8=0x00400010 -> write 0x00400010 to 31.
- Flush and reset: WB_flush together with a valid input -> no write, no count. SYS_reset asserted while a valid write is resident -> all outputs 0 next cycle. SYS_reset and WB_flush together -> same as reset.
- Counter wrap: with CNT_W=4, 17 consecutive valid instructions -> count reads 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared MIPS write-back definitions.
// Also consumed by the register file and MEM stage.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_LOAD = 2'd1,
    WB_SEL_LINK = 2'd2,
    WB_SEL_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LH  = 3'd1,
    LD_LHU = 3'd2,
    LD_LB  = 3'd3,
    LD_LBU = 3'd4
  } ld_type_e;

endpackage

// File: rtl/load_align.sv
// Little-endian load extraction and extension.
// Flags loads whose offset breaks natural alignment.
module load_align
  import wb_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [2:0]        type_i,
  input  logic [1:0]        off_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misalign_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = word_i[7:0];
    unique case (off_i)
      2'd0: byte_w = word_i[7:0];
      2'd1: byte_w = word_i[15:8];
      2'd2: byte_w = word_i[23:16];
      2'd3: byte_w = word_i[31:24];
    endcase
  end

  assign half_w = off_i[1] ? word_i[31:16]
                           : word_i[15:0];

  // Types 5-7 fall through to word behaviour.
  always_comb begin
    data_o     = word_i;
    misalign_o = (off_i != 2'b00);
    unique case (1'b1)
      (type_i == LD_LH): begin
        data_o     = {{16{half_w[15]}}, half_w};
        misalign_o = off_i[0];
      end
      (type_i == LD_LHU): begin
        data_o     = {16'h0000, half_w};
        misalign_o = off_i[0];
      end
      (type_i == LD_LB): begin
        data_o     = {{24{byte_w[7]}}, byte_w};
        misalign_o = 1'b0;
      end
      (type_i == LD_LBU): begin
        data_o     = {24'h000000, byte_w};
        misalign_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB register,
// result select, register file write port.
module wb_stage
  import wb_pkg::*;
#(
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int CNT_W  = 32
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              WB_flush,
  input  logic              WB_valid_in,
  input  logic              WB_reg_write_in,
  input  logic [ADDR_W-1:0] WB_address_wr_in,
  input  logic [1:0]        WB_sel_in,
  input  logic [2:0]        WB_load_type_in,
  input  logic [1:0]        WB_byte_offset_in,
  input  logic [DATA_W-1:0] WB_alu_result_in,
  input  logic [DATA_W-1:0] WB_mem_data_in,
  input  logic [DATA_W-1:0] WB_pc_plus8_in,
  output logic              REG_write_1,
  output logic [ADDR_W-1:0] REG_address_wr,
  output logic [DATA_W-1:0] REG_data_wb_in1,
  output logic              WB_misalign,
  output logic              WB_misalign_sticky,
  output logic [CNT_W-1:0]  WB_retire_count
);

  logic              valid_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        sel_q;
  logic [2:0]        lt_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] pc8_q;
  logic              sticky_q;
  logic              sticky_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic [DATA_W-1:0] ld_data;
  logic              ld_mis;
  logic              misalign;

  // A flushed slot is cleared entirely so it drives nothing stale.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset || WB_flush) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= 2'd0;
      lt_q    <= 3'd0;
      off_q   <= 2'd0;
      alu_q   <= '0;
      mem_q   <= '0;
      pc8_q   <= '0;
    end else begin
      valid_q <= WB_valid_in;
      rw_q    <= WB_reg_write_in;
      addr_q  <= WB_address_wr_in;
      sel_q   <= WB_sel_in;
      lt_q    <= WB_load_type_in;
      off_q   <= WB_byte_offset_in;
      alu_q   <= WB_alu_result_in;
      mem_q   <= WB_mem_data_in;
      pc8_q   <= WB_pc_plus8_in;
    end
  end

  load_align u_align (
    .word_i     (mem_q),
    .type_i     (lt_q),
    .off_i      (off_q),
    .data_o     (ld_data),
    .misalign_o (ld_mis)
  );

  assign misalign = valid_q
                  & (sel_q == WB_SEL_LOAD)
                  & ld_mis;

  always_comb begin
    sticky_d = sticky_q | misalign;
    cnt_d    = cnt_q;
    if (valid_q && !misalign)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    REG_data_wb_in1 = alu_q;
    unique case (sel_q)
      WB_SEL_LOAD: REG_data_wb_in1 = ld_data;
      WB_SEL_LINK: REG_data_wb_in1 = pc8_q;
      default:     REG_data_wb_in1 = alu_q;
    endcase
  end

  assign REG_write_1 = valid_q & rw_q
                     & (addr_q != '0)
                     & ~misalign;

  assign REG_address_wr     = addr_q;
  assign WB_misalign        = misalign;
  assign WB_misalign_sticky = sticky_q;
  assign WB_retire_count    = cnt_q;

endmodule
